seg_rw_param: RTL and testbench

SEG_RW_PARAM -- requirements
Module: seg_rw_param

---
 rtl/seg_rw_param_if.sv | 29 ++
 rtl/seg_rw_param.sv | 142 ++++++++++++++
 tb/tb_seg_rw_param.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg_rw_param_if.sv
// seg_rw_param_if
//   Token/result handshake bundle for seg_rw_param.
//   Request side : seq_mode, addr_d, dataW_d, write_d, in_valid -> in_ready
//   Result side  : dataR_d, out_valid -> out_ready
//   master = token producer / result consumer, slave = the memory block.
interface seg_rw_param_if #(
    parameter int DW = 8,
    parameter int AW = 4
);
    logic          seq_mode;
    logic [AW-1:0] addr_d;
    logic [DW-1:0] dataW_d;
    logic          write_d;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] dataR_d;
    logic          out_valid;
    logic          out_ready;

    modport master (
        output seq_mode, addr_d, dataW_d, write_d, in_valid, out_ready,
        input  in_ready, dataR_d, out_valid
    );

    modport slave (
        input  seq_mode, addr_d, dataW_d, write_d, in_valid, out_ready,
        output in_ready, dataR_d, out_valid
    );
endinterface

// File: rtl/seg_rw_param.sv
// seg_rw_param
//   DEPTH x DW register memory behind a valid/ready token port. Each accepted
//   token is either a write (no result) or a read (one result, 1-cycle
//   latency, held until consumed). Addressing is either the token's addr_d
//   or an internal pointer that advances on every sequential-mode token.
//   Out-of-range accesses are consumed, leave memory untouched, return 0 for
//   reads and raise the sticky err flag.
//
// Ports
//   clock    : rising-edge clock
//   reset    : asynchronous, active-low
//   bus      : seg_rw_param_if.slave (token in / result out handshake)
//   err      : sticky out-of-range flag
//   clr_err  : synchronous clear of err (a same-edge set wins)
//
// Result slot FSM
//   state   | meaning
//   S_EMPTY | no result pending; out_valid = 0
//   S_FULL  | result in dataR_d waiting for out_ready; out_valid = 1
module seg_rw_param #(
    parameter int DW    = 8,
    parameter int AW    = 4,
    parameter int DEPTH = 16
) (
    input  logic               clock,
    input  logic               reset,
    seg_rw_param_if.slave      bus,
    output logic               err,
    input  logic               clr_err
);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } slot_t;

    slot_t          state_q, state_d;
    logic [DW-1:0]  rdata_q, rdata_d;
    logic [AW-1:0]  ptr_q, ptr_d;
    logic           err_q, err_d;
    logic           run_q;

    logic [DW-1:0]  mem [DEPTH];

    logic [AW-1:0]  eff_addr;
    logic           in_range;
    logic           accept;
    logic           rd_accept;
    logic           wr_en;
    logic [DW-1:0]  rd_word;

    // run_q comes up one edge after reset release, so no token can be
    // accepted while reset is low (the memory itself has no reset) and the
    // reset net never feeds the data path of a flop.
    assign bus.in_ready  = run_q && ((state_q == S_EMPTY) || bus.out_ready);
    assign bus.out_valid = (state_q == S_FULL);
    assign bus.dataR_d   = rdata_q;
    assign err           = err_q;

    always_comb begin
        eff_addr  = bus.seq_mode ? ptr_q : bus.addr_d;
        in_range  = (32'(eff_addr) < 32'(DEPTH));
        accept    = bus.in_valid && bus.in_ready;
        rd_accept = accept && !bus.write_d;
        wr_en     = accept && bus.write_d && in_range;
        rd_word   = '0;
        if (in_range) begin
            rd_word = mem[eff_addr];
        end
    end

    // Result slot: a read accepted on the same edge that drains the slot
    // refills it, which is what gives one token per cycle with out_ready=1.
    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        case (state_q)
            S_EMPTY: begin
                if (rd_accept) begin
                    state_d = S_FULL;
                    rdata_d = rd_word;
                end
            end
            S_FULL: begin
                if (rd_accept) begin
                    rdata_d = rd_word;
                end else if (bus.out_ready) begin
                    state_d = S_EMPTY;
                end
            end
            default: begin
                state_d = S_EMPTY;
            end
        endcase
    end

    // Pointer advances on every sequential token, read or write, in range
    // by construction since it wraps at DEPTH-1.
    always_comb begin
        ptr_d = ptr_q;
        if (accept && bus.seq_mode) begin
            if (32'(ptr_q) == 32'(DEPTH - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = ptr_q + 1'b1;
            end
        end
    end

    always_comb begin
        err_d = err_q;
        if (accept && !in_range) begin
            err_d = 1'b1;
        end else if (clr_err) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_EMPTY;
            rdata_q <= '0;
            ptr_q   <= '0;
            err_q   <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            ptr_q   <= ptr_d;
            err_q   <= err_d;
            run_q   <= 1'b1;
        end
    end

    // Contents survive reset on purpose.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[eff_addr] <= bus.dataW_d;
        end
    end

endmodule

// File: tb/tb_seg_rw_param.sv
module tb_seg_rw_param;

    logic clock;
    logic reset;
    logic err16, clr16;
    logic err12, clr12;
    int   checks;
    int   errors;

    seg_rw_param_if #(.DW(8), .AW(4)) b16 ();
    seg_rw_param_if #(.DW(8), .AW(4)) b12 ();

    seg_rw_param #(.DW(8), .AW(4), .DEPTH(16)) dut16 (
        .clock   (clock),
        .reset   (reset),
        .bus     (b16),
        .err     (err16),
        .clr_err (clr16)
    );

    seg_rw_param #(.DW(8), .AW(4), .DEPTH(12)) dut12 (
        .clock   (clock),
        .reset   (reset),
        .bus     (b12),
        .err     (err12),
        .clr_err (clr12)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tok16(input logic v, input logic w, input logic sm,
                         input logic [3:0] a, input logic [7:0] d);
        b16.in_valid = v;
        b16.write_d  = w;
        b16.seq_mode = sm;
        b16.addr_d   = a;
        b16.dataW_d  = d;
    endtask

    task automatic tok12(input logic v, input logic w, input logic sm,
                         input logic [3:0] a, input logic [7:0] d);
        b12.in_valid = v;
        b12.write_d  = w;
        b12.seq_mode = sm;
        b12.addr_d   = a;
        b12.dataW_d  = d;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tok16(0, 0, 0, 0, 0);
        tok12(0, 0, 0, 0, 0);
        b16.out_ready = 1'b1;
        b12.out_ready = 1'b1;
        clr16 = 1'b0;
        clr12 = 1'b0;
        #12;
        checks++;
        if (b16.out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid got %b exp 0", b16.out_valid);
        end
        checks++;
        if (b16.dataR_d !== 8'h00) begin
            errors++; $display("FAIL reset_dataR got %h exp 00", b16.dataR_d);
        end
        checks++;
        if (err16 !== 1'b0 || err12 !== 1'b0) begin
            errors++; $display("FAIL reset_err got %b/%b exp 0/0", err16, err12);
        end
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
    endtask

    task automatic test_write_read();
        @(negedge clock);
        tok16(1, 1, 0, 4'd3, 8'hA5);
        @(negedge clock);
        #1;
        checks++;
        if (b16.out_valid !== 1'b0) begin
            errors++; $display("FAIL write_no_output got %b exp 0", b16.out_valid);
        end
        tok16(1, 0, 0, 4'd3, 8'h00);
        @(posedge clock);
        #1;
        checks++;
        if (b16.out_valid !== 1'b1 || b16.dataR_d !== 8'hA5) begin
            errors++;
            $display("FAIL wr_rd got v=%b d=%h exp v=1 d=a5", b16.out_valid, b16.dataR_d);
        end
        @(negedge clock);
        tok16(0, 0, 0, 0, 0);
        @(posedge clock);
        #1;
        checks++;
        if (b16.out_valid !== 1'b0) begin
            errors++; $display("FAIL wr_rd_drain got %b exp 0", b16.out_valid);
        end
    endtask

    task automatic test_backpressure();
        @(negedge clock);
        tok16(1, 1, 0, 4'd5, 8'h3C);
        @(negedge clock);
        tok16(1, 0, 0, 4'd5, 8'h00);
        b16.out_ready = 1'b0;
        @(posedge clock);
        #1;
        checks++;
        if (b16.out_valid !== 1'b1 || b16.dataR_d !== 8'h3C) begin
            errors++;
            $display("FAIL bp_first got v=%b d=%h exp v=1 d=3c", b16.out_valid, b16.dataR_d);
        end
        // A write token stays offered during the stall; it must not land.
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            tok16(1, 1, 0, 4'd5, 8'hEE);
            #1;
            checks++;
            if (b16.in_ready !== 1'b0 || b16.out_valid !== 1'b1 || b16.dataR_d !== 8'h3C) begin
                errors++;
                $display("FAIL bp_hold[%0d] got rdy=%b v=%b d=%h exp rdy=0 v=1 d=3c",
                         i, b16.in_ready, b16.out_valid, b16.dataR_d);
            end
        end
        @(negedge clock);
        tok16(0, 0, 0, 0, 0);
        b16.out_ready = 1'b1;
        #1;
        checks++;
        if (b16.in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release_ready got %b exp 1", b16.in_ready);
        end
        @(posedge clock);
        #1;
        checks++;
        if (b16.out_valid !== 1'b0 || b16.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_released got v=%b rdy=%b exp v=0 rdy=1", b16.out_valid, b16.in_ready);
        end
        @(negedge clock);
        tok16(1, 0, 0, 4'd5, 8'h00);
        @(posedge clock);
        #1;
        checks++;
        if (b16.dataR_d !== 8'h3C) begin
            errors++; $display("FAIL bp_stalled_write_dropped got %h exp 3c", b16.dataR_d);
        end
        @(negedge clock);
        tok16(0, 0, 0, 0, 0);
    endtask

    task automatic test_seq_wrap();
        logic [7:0] exp_d [5];
        logic [3:0] rd_a  [5];
        logic       rd_sm [5];
        exp_d = '{8'h10, 8'h01, 8'h0F, 8'h01, 8'h02};
        rd_a  = '{4'd0, 4'd1, 4'd15, 4'd0, 4'd0};
        rd_sm = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 17; i++) begin
            @(negedge clock);
            tok16(1, 1, 1, 4'd0, 8'(i));
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            tok16(1, 0, rd_sm[i], rd_a[i], 8'h00);
            @(posedge clock);
            #1;
            checks++;
            if (b16.out_valid !== 1'b1 || b16.dataR_d !== exp_d[i]) begin
                errors++;
                $display("FAIL seq_wrap[%0d] got v=%b d=%h exp v=1 d=%h",
                         i, b16.out_valid, b16.dataR_d, exp_d[i]);
            end
        end
        @(negedge clock);
        tok16(0, 0, 0, 0, 0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            tok16(1, 1, 0, 4'(i), 8'(8'h40 + i));
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            tok16(1, 0, 0, 4'(i), 8'h00);
            #1;
            checks++;
            if (b16.in_ready !== 1'b1) begin
                errors++; $display("FAIL b2b_ready[%0d] got %b exp 1", i, b16.in_ready);
            end
            @(posedge clock);
            #1;
            checks++;
            if (b16.out_valid !== 1'b1 || b16.dataR_d !== 8'(8'h40 + i)) begin
                errors++;
                $display("FAIL b2b_data[%0d] got v=%b d=%h exp v=1 d=%h",
                         i, b16.out_valid, b16.dataR_d, 8'(8'h40 + i));
            end
        end
        @(negedge clock);
        tok16(0, 0, 0, 0, 0);
        @(posedge clock);
        #1;
        checks++;
        if (b16.out_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_drain got %b exp 0", b16.out_valid);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clock);
        tok16(1, 1, 0, 4'd9, 8'h77);
        @(negedge clock);
        tok16(1, 0, 0, 4'd9, 8'h00);
        b16.out_ready = 1'b0;
        @(posedge clock);
        #1;
        checks++;
        if (b16.out_valid !== 1'b1) begin
            errors++; $display("FAIL rmid_pending got %b exp 1", b16.out_valid);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (b16.out_valid !== 1'b0 || b16.dataR_d !== 8'h00 || err16 !== 1'b0) begin
            errors++;
            $display("FAIL rmid_async got v=%b d=%h e=%b exp v=0 d=00 e=0",
                     b16.out_valid, b16.dataR_d, err16);
        end
        @(negedge clock);
        tok16(1, 1, 0, 4'd9, 8'h11);
        b16.out_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        tok16(0, 0, 0, 0, 0);
        @(posedge clock);
        #1;
        checks++;
        if (b16.out_valid !== 1'b0) begin
            errors++; $display("FAIL rmid_discard got %b exp 0", b16.out_valid);
        end
        @(negedge clock);
        tok16(1, 0, 0, 4'd9, 8'h00);
        @(posedge clock);
        #1;
        checks++;
        if (b16.out_valid !== 1'b1 || b16.dataR_d !== 8'h77) begin
            errors++;
            $display("FAIL rmid_mem_kept got v=%b d=%h exp v=1 d=77", b16.out_valid, b16.dataR_d);
        end
        @(negedge clock);
        tok16(1, 0, 1, 4'd0, 8'h00);
        @(posedge clock);
        #1;
        checks++;
        if (b16.dataR_d !== 8'h40) begin
            errors++; $display("FAIL rmid_ptr_reset got %h exp 40", b16.dataR_d);
        end
        @(negedge clock);
        tok16(0, 0, 0, 0, 0);
    endtask

    task automatic test_out_of_range();
        logic       v_t [9];
        logic       w_t [9];
        logic [3:0] a_t [9];
        logic [7:0] d_t [9];
        logic       c_t [9];
        logic       e_err [9];
        logic       chk_rd [9];
        logic [7:0] e_rd [9];
        //         wr@2  rd@13 clr   wr@12 wr@14+clr clr  wr@11 rd@11 rd@2
        v_t    = '{1,    1,    0,    1,    1,        0,   1,    1,    1};
        w_t    = '{1,    0,    0,    1,    1,        0,   1,    0,    0};
        a_t    = '{2,    13,   0,    12,   14,       0,   11,   11,   2};
        d_t    = '{8'h5A,0,    0,    8'hC3,8'hC3,    0,   8'h33,0,    0};
        c_t    = '{0,    0,    1,    0,    1,        1,   0,    0,    0};
        e_err  = '{0,    1,    0,    1,    1,        0,   0,    0,    0};
        chk_rd = '{0,    1,    0,    0,    0,        0,   0,    1,    1};
        e_rd   = '{0,    8'h00,0,    0,    0,        0,   0,    8'h33,8'h5A};
        for (int i = 0; i < 9; i++) begin
            @(negedge clock);
            tok12(v_t[i], w_t[i], 1'b0, a_t[i], d_t[i]);
            clr12 = c_t[i];
            @(posedge clock);
            #1;
            checks++;
            if (err12 !== e_err[i]) begin
                errors++; $display("FAIL oor_err[%0d] got %b exp %b", i, err12, e_err[i]);
            end
            if (chk_rd[i]) begin
                checks++;
                if (b12.out_valid !== 1'b1 || b12.dataR_d !== e_rd[i]) begin
                    errors++;
                    $display("FAIL oor_rd[%0d] got v=%b d=%h exp v=1 d=%h",
                             i, b12.out_valid, b12.dataR_d, e_rd[i]);
                end
            end
        end
        @(negedge clock);
        tok12(0, 0, 0, 0, 0);
        clr12 = 1'b0;
    endtask

    // Transaction-level model of the DEPTH=12 instance.
    task automatic test_random();
        logic [7:0] m_mem [12];
        int         m_ptr;
        logic       m_ov;
        logic [7:0] m_dr;
        logic       m_err;
        logic       v, w, sm, ordy, clr, exp_ir, acc, oor;
        logic [3:0] a;
        logic [7:0] d;
        int         eff;

        @(negedge clock);
        reset = 1'b0;
        tok12(0, 0, 0, 0, 0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        m_ptr = 0;
        m_ov  = 1'b0;
        m_dr  = 8'h00;
        m_err = 1'b0;

        for (int c = 0; c < 412; c++) begin
            @(negedge clock);
            if (c < 12) begin
                v = 1; w = 1; sm = 0; a = 4'(c); d = 8'($urandom); ordy = 1; clr = 0;
            end else begin
                v    = ($urandom % 4) != 0;
                w    = 1'($urandom);
                sm   = ($urandom % 3) == 0;
                a    = 4'($urandom);
                d    = 8'($urandom);
                ordy = ($urandom % 4) != 0;
                clr  = ($urandom % 8) == 0;
            end
            tok12(v, w, sm, a, d);
            b12.out_ready = ordy;
            clr12 = clr;
            #1;
            exp_ir = !m_ov || ordy;
            checks++;
            if (b12.in_ready !== exp_ir) begin
                errors++; $display("FAIL rnd_ready[%0d] got %b exp %b", c, b12.in_ready, exp_ir);
            end
            acc = v && exp_ir;
            eff = sm ? m_ptr : int'(a);
            oor = eff >= 12;
            @(posedge clock);
            if (acc && !w) begin
                m_ov = 1'b1;
                m_dr = oor ? 8'h00 : m_mem[eff];
            end else if (ordy) begin
                m_ov = 1'b0;
            end
            if (acc && w && !oor) m_mem[eff] = d;
            if (acc && oor) m_err = 1'b1;
            else if (clr)   m_err = 1'b0;
            if (acc && sm)  m_ptr = (m_ptr == 11) ? 0 : m_ptr + 1;
            #1;
            checks++;
            if (b12.out_valid !== m_ov || err12 !== m_err) begin
                errors++;
                $display("FAIL rnd_flags[%0d] got v=%b e=%b exp v=%b e=%b",
                         c, b12.out_valid, err12, m_ov, m_err);
            end
            if (m_ov) begin
                checks++;
                if (b12.dataR_d !== m_dr) begin
                    errors++;
                    $display("FAIL rnd_data[%0d] got %h exp %h", c, b12.dataR_d, m_dr);
                end
            end
        end
        @(negedge clock);
        tok12(0, 0, 0, 0, 0);
        clr12 = 1'b0;
        b12.out_ready = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_write_read();
        test_backpressure();
        test_seq_wrap();
        test_back_to_back();
        test_reset_mid();
        test_out_of_range();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
